unidade_controle_multiciclo: RTL

- Multicycle MIPS control FSM. It is the producer of the select and enable signals consumed by the datapath muxes, including the 3-bit ULAb select for ALU operand B.
- Sits between the instruction register (opcode and funct fields) and the datapath: PC, memory, register file, ULA, and the source muxes.
- Moore outputs decoded from the current state. Supports R-type (add/sub/and/or/slt), addi, lw, sw, beq and j, with a configurable memory wait.

---
 rtl/unidade_controle_multiciclo_if.sv | 34 +++
 rtl/unidade_controle_multiciclo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo_if.sv
// rtl/unidade_controle_multiciclo_if.sv - instruction fields in, datapath selects/enables out
// The control unit drives through the master modport; the datapath side uses slave.
interface unidade_controle_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ovf;
  logic       PCwrite;
  logic       PCwriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       ULAa;
  logic [2:0] ULAb;
  logic [2:0] ULAop;
  logic [1:0] PCSource;
  logic       EPCwrite;
  logic [3:0] estado;

  modport master (
    input  opcode, funct, ovf,
    output PCwrite, PCwriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemToReg, ULAa, ULAb, ULAop, PCSource, EPCwrite, estado
  );

  modport slave (
    output opcode, funct, ovf,
    input  PCwrite, PCwriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemToReg, ULAa, ULAb, ULAop, PCSource, EPCwrite, estado
  );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// rtl/unidade_controle_multiciclo.sv - multicycle MIPS control FSM with Moore outputs
// Optional overflow exception path enabled by UNIDADE_CONTROLE_OVF_EN.
module unidade_controle_multiciclo #(
  parameter int MEM_WAIT = 0
) (
  input logic clk,
  input logic reset,
  unidade_controle_multiciclo_if.master ctl
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEMADDR   = 4'd3,
    S_MEMREAD   = 4'd4,
    S_MEMWB     = 4'd5,
    S_MEMWRITE  = 4'd6,
    S_EXEC_R    = 4'd7,
    S_RWB       = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
`ifdef UNIDADE_CONTROLE_OVF_EN
    , S_EXCEPTION = 4'd13
`endif
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic [2:0] alu_op_q;
  logic       is_lw_q;
  logic       mem_last;
  logic       r_ok;
  logic [2:0] r_op;

`ifdef UNIDADE_CONTROLE_OVF_EN
  logic addsub_q;
`else
  logic unused_ovf;
  assign unused_ovf = ctl.ovf;
`endif

  assign mem_last   = (cnt == WAIT_LAST);
  assign ctl.estado = state;

  always_comb begin
    r_ok = 1'b1;
    r_op = 3'b000;
    case (ctl.funct)
      6'h20:   r_op = 3'b000;
      6'h22:   r_op = 3'b001;
      6'h24:   r_op = 3'b010;
      6'h25:   r_op = 3'b011;
      6'h2A:   r_op = 3'b100;
      default: r_ok = 1'b0;
    endcase
  end

  // Instruction fields are captured once in DECODE so later states ignore IR changes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_RESET;
      cnt      <= 3'd0;
      alu_op_q <= 3'd0;
      is_lw_q  <= 1'b0;
`ifdef UNIDADE_CONTROLE_OVF_EN
      addsub_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt == state) ? cnt + 3'd1 : 3'd0;
      if (state == S_DECODE) begin
        alu_op_q <= r_op;
        is_lw_q  <= (ctl.opcode == 6'h23);
`ifdef UNIDADE_CONTROLE_OVF_EN
        addsub_q <= (ctl.funct == 6'h20) || (ctl.funct == 6'h22);
`endif
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    ctl.PCwrite     = 1'b0;
    ctl.PCwriteCond = 1'b0;
    ctl.IorD        = 1'b0;
    ctl.MemRead     = 1'b0;
    ctl.MemWrite    = 1'b0;
    ctl.IRWrite     = 1'b0;
    ctl.RegWrite    = 1'b0;
    ctl.RegDst      = 1'b0;
    ctl.MemToReg    = 1'b0;
    ctl.ULAa        = 1'b0;
    ctl.ULAb        = 3'b000;
    ctl.ULAop       = 3'b000;
    ctl.PCSource    = 2'b00;
    ctl.EPCwrite    = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        ctl.MemRead = 1'b1;
        ctl.ULAb    = 3'b010;
        if (mem_last) begin
          ctl.IRWrite = 1'b1;
          ctl.PCwrite = 1'b1;
          state_nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.ULAb = 3'b100;
        case (ctl.opcode)
          6'h00:        state_nxt = r_ok ? S_EXEC_R : S_FETCH;
          6'h08:        state_nxt = S_ADDI_EXEC;
          6'h23, 6'h2B: state_nxt = S_MEMADDR;
          6'h04:        state_nxt = S_BRANCH;
          6'h02:        state_nxt = S_JUMP;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADDR: begin
        ctl.ULAa  = 1'b1;
        ctl.ULAb  = 3'b001;
        state_nxt = is_lw_q ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctl.IorD    = 1'b1;
        ctl.MemRead = 1'b1;
        if (mem_last) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.RegWrite = 1'b1;
        ctl.MemToReg = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWRITE: begin
        ctl.IorD     = 1'b1;
        ctl.MemWrite = 1'b1;
        if (mem_last) state_nxt = S_FETCH;
      end
      S_EXEC_R: begin
        ctl.ULAa  = 1'b1;
        ctl.ULAop = alu_op_q;
`ifdef UNIDADE_CONTROLE_OVF_EN
        state_nxt = (ctl.ovf && addsub_q) ? S_EXCEPTION : S_RWB;
`else
        state_nxt = S_RWB;
`endif
      end
      S_RWB: begin
        ctl.RegWrite = 1'b1;
        ctl.RegDst   = 1'b1;
        ctl.ULAop    = alu_op_q;
        state_nxt    = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ctl.ULAa  = 1'b1;
        ctl.ULAb  = 3'b001;
`ifdef UNIDADE_CONTROLE_OVF_EN
        state_nxt = ctl.ovf ? S_EXCEPTION : S_ADDI_WB;
`else
        state_nxt = S_ADDI_WB;
`endif
      end
      S_ADDI_WB: begin
        ctl.RegWrite = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BRANCH: begin
        ctl.ULAa        = 1'b1;
        ctl.ULAop       = 3'b001;
        ctl.PCwriteCond = 1'b1;
        ctl.PCSource    = 2'b01;
        state_nxt       = S_FETCH;
      end
      S_JUMP: begin
        ctl.PCwrite  = 1'b1;
        ctl.PCSource = 2'b10;
        state_nxt    = S_FETCH;
      end
`ifdef UNIDADE_CONTROLE_OVF_EN
      // ULA computes PC-4 so EPC holds the faulting instruction address.
      S_EXCEPTION: begin
        ctl.EPCwrite = 1'b1;
        ctl.ULAb     = 3'b010;
        ctl.ULAop    = 3'b001;
        ctl.PCwrite  = 1'b1;
        ctl.PCSource = 2'b11;
        state_nxt    = S_FETCH;
      end
`endif
      default: state_nxt = S_RESET;
    endcase
  end

endmodule
